wb_sequencer: RTL and testbench

//  Sequences the register-file writeback path of the multicycle CPU. Queues writeback

---
 rtl/wb_sequencer_if.sv | 27 ++
 rtl/wb_sequencer.sv | 98 +++++++++
 tb/tb_wb_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if: writeback request/retire bundle between control FSM, sequencer and register file
//   master: req_valid/req_src/req_dst/flush out; req_ready, memto_reg, reg_write, write_reg, wb_done, busy, err_src in
//   slave : the mirror image, driven by wb_sequencer
interface wb_sequencer_if #(
  parameter int SRC_W  = 4,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [SRC_W-1:0]  req_src;
  logic [ADDR_W-1:0] req_dst;
  logic              flush;
  logic [SRC_W-1:0]  memto_reg;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic              wb_done;
  logic              busy;
  logic              err_src;
  modport master (
    output req_valid, req_src, req_dst, flush,
    input  req_ready, memto_reg, reg_write, write_reg, wb_done, busy, err_src
  );
  modport slave (
    input  req_valid, req_src, req_dst, flush,
    output req_ready, memto_reg, reg_write, write_reg, wb_done, busy, err_src
  );
endinterface

// File: rtl/wb_sequencer.sv
// wb_sequencer: queues writeback requests, holds the MemtoReg select SETTLE_CYC cycles, then pulses RegWrite
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_sequencer_if.slave (request in, mux select / register-file write port out)
module wb_sequencer #(
  parameter int DEPTH      = 2,
  parameter int SETTLE_CYC = 1,
  parameter int SRC_W      = 4,
  parameter int ADDR_W     = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_sequencer_if.slave  bus
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [1:0] {IDLE, SELECT, WRITE} state_t;
  state_t            r_state;
  logic [SRC_W-1:0]  r_src [DEPTH];
  logic [ADDR_W-1:0] r_dst [DEPTH];
  logic [CW-1:0]     r_count;
  logic [SCW-1:0]    r_cnt;
  logic [SRC_W-1:0]  r_memto;
  logic [ADDR_W-1:0] r_wreg;
  logic              r_rw, r_done, r_err;
  logic [SRC_W-1:0]  w_src_n [DEPTH];
  logic [ADDR_W-1:0] w_dst_n [DEPTH];
  logic [CW-1:0]     w_count_n, w_slot;
  logic              w_legal, w_push, w_pop;
  assign w_legal   = bus.req_src <= SRC_W'(11);
  assign w_push    = bus.req_valid & bus.req_ready & w_legal;
  assign w_pop     = r_state == WRITE;
  assign w_slot    = r_count - CW'(w_pop);
  assign w_count_n = bus.flush ? '0 : r_count - CW'(w_pop) + CW'(w_push);
  // Shift-register FIFO: slot 0 is always the head, a pop shifts everything down.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_src_n[i] = (w_pop && i < DEPTH - 1) ? r_src[i+1] : r_src[i];
      w_dst_n[i] = (w_pop && i < DEPTH - 1) ? r_dst[i+1] : r_dst[i];
      if (w_push && w_slot == CW'(i)) begin
        w_src_n[i] = bus.req_src;
        w_dst_n[i] = bus.req_dst;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '{default: '0};
      r_dst   <= '{default: '0};
      r_count <= '0;
      r_cnt   <= '0;
      r_memto <= SRC_W'(6);
      r_wreg  <= '0;
      r_rw    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_src   <= w_src_n;
      r_dst   <= w_dst_n;
      r_count <= w_count_n;
      if (bus.req_valid && !w_legal) r_err <= 1'b1;
      case (r_state)
        IDLE:
          if (r_count != '0 && !bus.flush) begin
            r_state <= SELECT;
            r_memto <= r_src[0];
            r_cnt   <= SCW'(SETTLE_CYC - 1);
          end
        SELECT:
          if (bus.flush) r_state <= IDLE;
          else if (r_cnt == '0) begin
            r_state <= WRITE;
            r_wreg  <= r_dst[0];
            r_rw    <= r_dst[0] != '0;
            r_done  <= 1'b1;
          end else r_cnt <= r_cnt - 1'b1;
        WRITE: begin
          r_rw   <= 1'b0;
          r_done <= 1'b0;
          // Next head comes from the post-pop/post-push view; flush forces the count to zero.
          if (w_count_n != '0) begin
            r_state <= SELECT;
            r_memto <= w_src_n[0];
            r_cnt   <= SCW'(SETTLE_CYC - 1);
          end else r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = r_count < CW'(DEPTH);
  assign bus.busy      = r_state != IDLE || r_count != '0;
  assign bus.memto_reg = r_memto;
  assign bus.reg_write = r_rw;
  assign bus.write_reg = r_wreg;
  assign bus.wb_done   = r_done;
  assign bus.err_src   = r_err;
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed and random stimulus against a queue-based writeback model
module tb_wb_sequencer;
  localparam int DEPTH  = 2;
  localparam int SETTLE = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_sequencer_if #(.SRC_W(4), .ADDR_W(5)) bus();
  wb_sequencer #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE), .SRC_W(4), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [3:0] q_src[$];
  logic [4:0] q_dst[$];
  bit         act, m_push, m_retire;
  int         age;
  logic [3:0] e_memto;
  logic [4:0] e_wreg;
  logic       e_rw, e_done, e_err;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_src.delete(); q_dst.delete();
      act = 0; age = 0;
      e_memto = 4'h6; e_wreg = '0; e_rw = 0; e_done = 0; e_err = 0;
    end else begin
      m_push = bus.req_valid && q_src.size() < DEPTH && bus.req_src <= 11;
      if (bus.req_valid && bus.req_src > 11) e_err = 1;
      e_rw = 0; e_done = 0; m_retire = 0;
      if (act && age == SETTLE) begin
        void'(q_src.pop_front()); void'(q_dst.pop_front());
        act = 0; m_retire = 1;
      end else if (act) begin
        if (bus.flush) act = 0;
        else begin
          age++;
          if (age == SETTLE) begin
            e_wreg = q_dst[0]; e_rw = q_dst[0] != 0; e_done = 1;
          end
        end
      end else if (q_src.size() > 0 && !bus.flush) begin
        act = 1; age = 0; e_memto = q_src[0];
      end
      if (m_push) begin q_src.push_back(bus.req_src); q_dst.push_back(bus.req_dst); end
      if (bus.flush) begin q_src.delete(); q_dst.delete(); end
      if (m_retire && q_src.size() > 0) begin act = 1; age = 0; e_memto = q_src[0]; end
    end
  end
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic [4:0] lg_wreg[$];
  logic [3:0] lg_memto[$];
  logic       lg_rw[$];
  int         lg_cyc[$];
  always @(negedge clk) begin
    chk("memto_reg", bus.memto_reg, e_memto);
    chk("reg_write", bus.reg_write, e_rw);
    chk("write_reg", bus.write_reg, e_wreg);
    chk("wb_done", bus.wb_done, e_done);
    chk("err_src", bus.err_src, e_err);
    chk("req_ready", bus.req_ready, q_src.size() < DEPTH);
    chk("busy", bus.busy, act || q_src.size() > 0);
    if (bus.wb_done) begin
      lg_wreg.push_back(bus.write_reg); lg_memto.push_back(bus.memto_reg);
      lg_rw.push_back(bus.reg_write); lg_cyc.push_back(cyc);
    end
  end
  task automatic drive(input logic v, input logic [3:0] s, input logic [4:0] d, input logic f);
    bus.req_valid = v; bus.req_src = s; bus.req_dst = d; bus.flush = f;
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic clr();
    lg_wreg.delete(); lg_memto.delete(); lg_rw.delete(); lg_cyc.delete();
  endtask
  initial begin
    int n;
    drive(0, 0, 0, 0);
    step(2);
    chk("rst memto", bus.memto_reg, 6);
    chk("rst ready", bus.req_ready, 1);
    chk("rst busy", bus.busy, 0);
    chk("rst err", bus.err_src, 0);
    rst_n = 1'b1;
    step();
    drive(1, 6, 8, 0); step();
    drive(0, 0, 0, 0); step();
    chk("t1 memto E1", bus.memto_reg, 6);
    chk("t1 rw E1", bus.reg_write, 0);
    step();
    chk("t1 rw E2", bus.reg_write, 1);
    chk("t1 wreg E2", bus.write_reg, 8);
    chk("t1 done E2", bus.wb_done, 1);
    step();
    chk("t1 busy after", bus.busy, 0);
    clr();
    drive(1, 2, 3, 0); step();
    drive(1, 4, 4, 0); step();
    chk("t2 ready full", bus.req_ready, 0);
    drive(1, 7, 5, 0);
    n = 0;
    while (!bus.req_ready && n < 10) begin step(); n++; end
    chk("t2 ready timeout", n < 10, 1);
    step();
    drive(0, 0, 0, 0);
    step(8);
    chk("t2 writes", lg_wreg.size(), 3);
    if (lg_wreg.size() == 3) begin
      chk("t2 wreg0", lg_wreg[0], 3); chk("t2 wreg1", lg_wreg[1], 4); chk("t2 wreg2", lg_wreg[2], 5);
      chk("t2 memto0", lg_memto[0], 2); chk("t2 memto1", lg_memto[1], 4); chk("t2 memto2", lg_memto[2], 7);
      chk("t2 gap01", lg_cyc[1] - lg_cyc[0], 2); chk("t2 gap12", lg_cyc[2] - lg_cyc[1], 2);
    end
    clr();
    drive(1, 4'hD, 5, 0); step();
    drive(0, 0, 0, 0);
    chk("t3 err set", bus.err_src, 1);
    step(4);
    chk("t3 no write", lg_wreg.size(), 0);
    drive(1, 9, 1, 0); step();
    drive(0, 0, 0, 0); step(5);
    chk("t3 writes", lg_wreg.size(), 1);
    if (lg_wreg.size() == 1) begin chk("t3 wreg", lg_wreg[0], 1); chk("t3 rw", lg_rw[0], 1); end
    chk("t3 err sticky", bus.err_src, 1);
    clr();
    drive(1, 3, 0, 0); step();
    drive(0, 0, 0, 0); step(4);
    chk("t4 retires", lg_wreg.size(), 1);
    if (lg_rw.size() == 1) chk("t4 rw zero", lg_rw[0], 0);
    chk("t4 busy", bus.busy, 0);
    clr();
    drive(1, 5, 6, 0); step();
    drive(0, 0, 0, 0); step();
    drive(0, 0, 0, 1); step();
    drive(0, 0, 0, 0);
    chk("t5a busy", bus.busy, 0);
    step(4);
    chk("t5a no write", lg_wreg.size(), 0);
    drive(1, 1, 7, 0); step();
    drive(1, 2, 9, 0); step();
    drive(0, 0, 0, 0); step();
    chk("t5b rw", bus.reg_write, 1);
    chk("t5b wreg", bus.write_reg, 7);
    drive(1, 3, 10, 1); step();
    drive(0, 0, 0, 0);
    chk("t5b rw low", bus.reg_write, 0);
    chk("t5b busy", bus.busy, 0);
    chk("t5b ready", bus.req_ready, 1);
    step(5);
    chk("t5b writes", lg_wreg.size(), 1);
    drive(1, 2, 3, 0); step();
    drive(1, 4, 4, 0); step();
    drive(0, 0, 0, 0);
    chk("t6 busy before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 memto", bus.memto_reg, 6);
    chk("t6 rw", bus.reg_write, 0);
    chk("t6 wreg", bus.write_reg, 0);
    chk("t6 done", bus.wb_done, 0);
    chk("t6 busy", bus.busy, 0);
    chk("t6 ready", bus.req_ready, 1);
    chk("t6 err", bus.err_src, 0);
    step();
    rst_n = 1'b1;
    clr();
    step(6);
    chk("t6 no write", lg_wreg.size(), 0);
    for (int i = 0; i < 400; i++) begin
      logic v, f;
      logic [3:0] s;
      logic [4:0] d;
      v = ($urandom % 100) < 60;
      s = (q_src.size() < DEPTH && $urandom % 20 == 0) ? 4'(12 + $urandom % 4) : 4'($urandom % 12);
      d = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom % 32);
      f = ($urandom % 25) == 0;
      drive(v, s, d, f);
      step();
    end
    drive(0, 0, 0, 0);
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
